// File: rtl/rbg_ant_pwr_acc.sv
// rbg_ant_pwr_acc
//   Passes 16 antenna RE streams through a fixed 2-cycle pipeline. For each
//   antenna it also accumulates RE power (I*I + Q*Q) over each RBG. The RBG
//   result is presented together with a load strobe and the RBG index, on the
//   same cycle as the last RE of that RBG leaves the block.
//
// Ports
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_rx_vld/sop/eop         RE valid, first / last RE of symbol
//   i_ant_data[16][32]       per antenna RE: [15:0] = I, [31:16] = Q (signed)
//   o_rx_vld/sop/eop         inputs delayed by 2 cycles
//   o_ant_data[16][32]       i_ant_data delayed by 2 cycles, unmodified
//   o_rbg_load               one-cycle pulse when o_ant_pwr/o_rbg_idx update
//   o_rbg_idx[4]             index of the RBG whose power is on o_ant_pwr
//   o_ant_pwr[16][32]        per antenna RBG power (shifted, saturated), held
module rbg_ant_pwr_acc #(
  parameter int RBG_RE    = 48,
  parameter int RBG_NUM   = 16,
  parameter int PWR_SHIFT = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_rx_vld,
  input  logic             i_rx_sop,
  input  logic             i_rx_eop,
  input  logic [15:0][31:0] i_ant_data,
  output logic             o_rx_vld,
  output logic             o_rx_sop,
  output logic             o_rx_eop,
  output logic [15:0][31:0] o_ant_data,
  output logic             o_rbg_load,
  output logic [3:0]       o_rbg_idx,
  output logic [15:0][31:0] o_ant_pwr
);

  localparam int ANT = 16;
  localparam int RW  = $clog2(RBG_RE);
  localparam int AW  = 32 + $clog2(RBG_RE);

  // Square of a signed 16-bit sample; the result (max 2^30) is non-negative.
  function automatic logic [31:0] sq16(input logic [15:0] x);
    logic signed [15:0] s;
    logic signed [31:0] p;
    s = x;
    p = s * s;
    return p;
  endfunction

  function automatic logic [31:0] pwr_sat(input logic [AW-1:0] v);
    logic [AW-1:0] s;
    s = v >> PWR_SHIFT;
    return (|s[AW-1:32]) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // RE / RBG position of the incoming RE; sop forces both to zero.
  logic [RW-1:0] re_cnt, cur_re;
  logic [3:0]    rbg_cnt, cur_rbg;
  logic          close_p0, first_p0;

  always_comb begin
    cur_re   = i_rx_sop ? '0 : re_cnt;
    cur_rbg  = i_rx_sop ? '0 : rbg_cnt;
    close_p0 = (cur_re == RW'(RBG_RE - 1)) || i_rx_eop;
    // RE 0 of an RBG restarts accumulation; covers sop, post-close and post-reset.
    first_p0 = (cur_re == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      re_cnt  <= '0;
      rbg_cnt <= '0;
    end else if (i_rx_vld) begin
      if (i_rx_eop) begin
        re_cnt  <= '0;
        rbg_cnt <= '0;
      end else if (close_p0) begin
        re_cnt  <= '0;
        rbg_cnt <= (cur_rbg == 4'(RBG_NUM - 1)) ? 4'd0 : cur_rbg + 4'd1;
      end else begin
        re_cnt  <= cur_re + RW'(1);
        rbg_cnt <= cur_rbg;
      end
    end
  end

  // ---- stage 1: registered squares ----
  logic             vld_p1, sop_p1, eop_p1, close_p1, first_p1;
  logic [3:0]       idx_p1;
  logic [15:0][31:0] data_p1;
  logic [31:0]      isq_p1 [ANT];
  logic [31:0]      qsq_p1 [ANT];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_p1   <= 1'b0;
      sop_p1   <= 1'b0;
      eop_p1   <= 1'b0;
      close_p1 <= 1'b0;
      first_p1 <= 1'b0;
      idx_p1   <= '0;
      data_p1  <= '0;
    end else begin
      vld_p1   <= i_rx_vld;
      sop_p1   <= i_rx_sop;
      eop_p1   <= i_rx_eop;
      close_p1 <= close_p0;
      first_p1 <= first_p0;
      idx_p1   <= cur_rbg;
      data_p1  <= i_ant_data;
    end
  end

  // Squares are only consumed when vld_p1 is set, so they carry no reset.
  always_ff @(posedge i_clk) begin
    for (int a = 0; a < ANT; a++) begin
      isq_p1[a] <= sq16(i_ant_data[a][15:0]);
      qsq_p1[a] <= sq16(i_ant_data[a][31:16]);
    end
  end

  // ---- stage 2: registered sum and accumulate ----
  logic [AW-1:0] acc     [ANT];
  logic [AW-1:0] acc_sum [ANT];

  always_comb begin
    for (int a = 0; a < ANT; a++) begin
      acc_sum[a] = (first_p1 ? '0 : acc[a]) + AW'(isq_p1[a]) + AW'(qsq_p1[a]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rx_vld   <= 1'b0;
      o_rx_sop   <= 1'b0;
      o_rx_eop   <= 1'b0;
      o_ant_data <= '0;
      o_rbg_load <= 1'b0;
      o_rbg_idx  <= '0;
      o_ant_pwr  <= '0;
      for (int a = 0; a < ANT; a++) acc[a] <= '0;
    end else begin
      o_rx_vld   <= vld_p1;
      o_rx_sop   <= sop_p1;
      o_rx_eop   <= eop_p1;
      o_ant_data <= data_p1;
      o_rbg_load <= vld_p1 & close_p1;
      if (vld_p1) begin
        for (int a = 0; a < ANT; a++) acc[a] <= acc_sum[a];
      end
      if (vld_p1 && close_p1) begin
        o_rbg_idx <= idx_p1;
        for (int a = 0; a < ANT; a++) o_ant_pwr[a] <= pwr_sat(acc_sum[a]);
      end
    end
  end

endmodule

// File: tb/tb_rbg_ant_pwr_acc.sv
// Directed bench for rbg_ant_pwr_acc. A second instance with PWR_SHIFT=0
// shares the stimulus and is used for the saturation case.
module tb_rbg_ant_pwr_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, vld, sop, eop;
  logic [15:0][31:0] din;

  logic a_vld, a_sop, a_eop, a_load;
  logic [3:0] a_idx;
  logic [15:0][31:0] a_data, a_pwr;
  logic s_vld, s_sop, s_eop, s_load;
  logic [3:0] s_idx;
  logic [15:0][31:0] s_data, s_pwr;

  int checks = 0;
  int passed = 0;

  // Expected pass-through: inputs delayed by two clock edges, tag = RE label.
  logic [15:0][31:0] d1, d2;
  logic v1, v2, s1, s2, e1, e2;
  int t1, t2;

  rbg_ant_pwr_acc dut (
    .i_clk(clk), .i_reset(rst), .i_rx_vld(vld), .i_rx_sop(sop), .i_rx_eop(eop),
    .i_ant_data(din), .o_rx_vld(a_vld), .o_rx_sop(a_sop), .o_rx_eop(a_eop),
    .o_ant_data(a_data), .o_rbg_load(a_load), .o_rbg_idx(a_idx), .o_ant_pwr(a_pwr)
  );

  rbg_ant_pwr_acc #(.PWR_SHIFT(0)) dut_sat (
    .i_clk(clk), .i_reset(rst), .i_rx_vld(vld), .i_rx_sop(sop), .i_rx_eop(eop),
    .i_ant_data(din), .o_rx_vld(s_vld), .o_rx_sop(s_sop), .o_rx_eop(s_eop),
    .o_ant_data(s_data), .o_rbg_load(s_load), .o_rbg_idx(s_idx), .o_ant_pwr(s_pwr)
  );

  // |I| = |Q| = 100 on every antenna (power 20000) with signs varying per RE.
  function automatic logic [15:0][31:0] mk(input int re);
    logic [15:0][31:0] d;
    logic [15:0] i, q;
    for (int a = 0; a < 16; a++) begin
      i = (((re + a) % 2) == 1) ? 16'hFF9C : 16'd100;
      q = ((re % 3) == 0) ? 16'hFF9C : 16'd100;
      d[a] = {q, i};
    end
    return d;
  endfunction

  // I = Q = -32768 on every antenna (power 2^31).
  function automatic logic [15:0][31:0] big();
    logic [15:0][31:0] d;
    for (int a = 0; a < 16; a++) d[a] = 32'h8000_8000;
    return d;
  endfunction

  function automatic logic [15:0][31:0] rep(input logic [31:0] v);
    logic [15:0][31:0] d;
    for (int a = 0; a < 16; a++) d[a] = v;
    return d;
  endfunction

  task automatic step(input logic v, input logic s, input logic e,
                      input logic [15:0][31:0] d, input int t);
    vld = v; sop = s; eop = e; din = d;
    @(posedge clk);
    if (rst) begin
      d1 = '0; d2 = '0; v1 = 0; v2 = 0; s1 = 0; s2 = 0; e1 = 0; e2 = 0; t1 = -1; t2 = -1;
    end else begin
      d2 = d1; v2 = v1; s2 = s1; e2 = e1; t2 = t1;
      d1 = d;  v1 = v;  s1 = s;  e1 = e;  t1 = v ? t : -1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1, 1, 0, mk(3), -1);
    step(1, 0, 0, mk(4), -1);
    checks++;
    if ({a_vld, a_sop, a_eop, a_load, a_idx} !== 8'h00 || a_data !== '0 || a_pwr !== '0)
      $display("FAIL reset_outputs got vld=%b sop=%b eop=%b load=%b idx=%0d data=%h pwr=%h required all 0",
               a_vld, a_sop, a_eop, a_load, a_idx, a_data, a_pwr);
    else passed++;
    checks++;
    if (s_load !== 1'b0 || s_pwr !== '0)
      $display("FAIL reset_sat got load=%b pwr=%h required 0", s_load, s_pwr);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic exp_ld;
    for (int c = 0; c < 98; c++) begin
      if (c < 96) step(1, c == 0, c == 95, mk(c), c);
      else step(0, 0, 0, mk(500 + c), -1);
      checks++;
      if ({a_vld, a_sop, a_eop} !== {v2, s2, e2} || a_data !== d2)
        $display("FAIL basic_pass c=%0d got %b%b%b %h required %b%b%b %h", c, a_vld, a_sop, a_eop, a_data, v2, s2, e2, d2);
      else passed++;
      exp_ld = (t2 == 47) || (t2 == 95);
      checks++;
      if (a_load !== exp_ld) $display("FAIL basic_load re=%0d got %b required %b", t2, a_load, exp_ld);
      else passed++;
      if (exp_ld) begin
        checks++;
        if (a_idx !== ((t2 == 95) ? 4'd1 : 4'd0) || a_pwr !== rep(32'd15000))
          $display("FAIL basic_pwr re=%0d got idx=%0d pwr=%h required idx=%0d pwr=all 15000", t2, a_idx, a_pwr, (t2 == 95));
        else passed++;
      end
    end
  endtask

  task automatic test_gaps();
    int re = 0;
    logic exp_ld;
    for (int c = 0; c < 150; c++) begin
      if (re < 96 && (c % 3) != 2) begin
        step(1, re == 0, re == 95, mk(re), re);
        re++;
      end else step(0, 0, 0, mk(700 + c), -1);
      checks++;
      if ({a_vld, a_sop, a_eop} !== {v2, s2, e2} || a_data !== d2)
        $display("FAIL gaps_pass c=%0d got %b%b%b %h required %b%b%b %h", c, a_vld, a_sop, a_eop, a_data, v2, s2, e2, d2);
      else passed++;
      exp_ld = (t2 == 47) || (t2 == 95);
      checks++;
      if (a_load !== exp_ld) $display("FAIL gaps_load re=%0d got %b required %b", t2, a_load, exp_ld);
      else passed++;
      if (exp_ld) begin
        checks++;
        if (a_idx !== ((t2 == 95) ? 4'd1 : 4'd0) || a_pwr !== rep(32'd15000))
          $display("FAIL gaps_pwr re=%0d got idx=%0d pwr=%h required idx=%0d pwr=all 15000", t2, a_idx, a_pwr, (t2 == 95));
        else passed++;
      end
    end
  endtask

  task automatic test_partial();
    logic [15:0][31:0] d, p47, p59;
    logic exp_ld;
    d = '0; d[5] = 32'h0000_8000;
    p47 = '0; p47[5] = 32'h3000_0000;
    p59 = '0; p59[5] = 32'h0C00_0000;
    for (int c = 0; c < 62; c++) begin
      if (c < 60) step(1, c == 0, c == 59, d, c);
      else step(0, 0, 0, '0, -1);
      exp_ld = (t2 == 47) || (t2 == 59);
      checks++;
      if (a_load !== exp_ld) $display("FAIL partial_load re=%0d got %b required %b", t2, a_load, exp_ld);
      else passed++;
      if (exp_ld) begin
        checks++;
        if (a_idx !== ((t2 == 59) ? 4'd1 : 4'd0) || a_pwr !== ((t2 == 59) ? p59 : p47))
          $display("FAIL partial_pwr re=%0d got idx=%0d pwr=%h required idx=%0d pwr=%h",
                   t2, a_idx, a_pwr, (t2 == 59), (t2 == 59) ? p59 : p47);
        else passed++;
      end
      if (t2 == 52) begin
        checks++;
        if (a_pwr !== p47 || a_idx !== 4'd0)
          $display("FAIL partial_hold got idx=%0d pwr=%h required idx=0 pwr=%h", a_idx, a_pwr, p47);
        else passed++;
      end
    end
  endtask

  task automatic test_sat();
    for (int c = 0; c < 50; c++) begin
      if (c < 48) step(1, c == 0, c == 47, big(), c);
      else step(0, 0, 0, '0, -1);
      checks++;
      if ({s_vld, s_sop, s_eop} !== {v2, s2, e2} || s_data !== d2 || s_load !== (t2 == 47))
        $display("FAIL sat_pass c=%0d got %b%b%b load=%b %h required %b%b%b load=%b %h",
                 c, s_vld, s_sop, s_eop, s_load, s_data, v2, s2, e2, (t2 == 47), d2);
      else passed++;
      if (t2 == 47) begin
        checks++;
        if (s_pwr !== rep(32'hFFFF_FFFF) || s_idx !== 4'd0)
          $display("FAIL sat_pwr got idx=%0d pwr=%h required idx=0 pwr=all ffffffff", s_idx, s_pwr);
        else passed++;
        checks++;
        if (a_load !== 1'b1 || a_pwr !== rep(32'h6000_0000))
          $display("FAIL sat_shift6 got load=%b pwr=%h required load=1 pwr=all 60000000", a_load, a_pwr);
        else passed++;
      end
    end
  endtask

  task automatic test_wrap();
    int nloads = 0;
    logic exp_ld;
    for (int c = 0; c < 818; c++) begin
      if (c < 816) step(1, c == 0, 0, mk(c), c);
      else step(0, 0, 0, '0, -1);
      exp_ld = (t2 >= 0) && ((t2 % 48) == 47);
      checks++;
      if (a_load !== exp_ld) $display("FAIL wrap_load re=%0d got %b required %b", t2, a_load, exp_ld);
      else passed++;
      if (exp_ld) begin
        nloads++;
        checks++;
        if (a_idx !== 4'((t2 / 48) % 16) || a_pwr !== rep(32'd15000))
          $display("FAIL wrap_idx load=%0d got idx=%0d pwr=%h required idx=%0d pwr=all 15000",
                   nloads, a_idx, a_pwr, (t2 / 48) % 16);
        else passed++;
      end
    end
    checks++;
    if (nloads != 17) $display("FAIL wrap_count got %0d loads required 17", nloads);
    else passed++;
    // close the symbol so the next test starts clean
    step(1, 0, 1, mk(1), -1);
    step(0, 0, 0, '0, -1);
    step(0, 0, 0, '0, -1);
  endtask

  task automatic test_sop_mid();
    logic exp_ld;
    for (int c = 0; c < 70; c++) begin
      if (c < 20) step(1, c == 0, 0, big(), c);
      else if (c < 68) step(1, c == 20, c == 67, mk(c), 80 + c);
      else step(0, 0, 0, '0, -1);
      exp_ld = (t2 == 147);
      checks++;
      if (a_load !== exp_ld) $display("FAIL sopmid_load tag=%0d got %b required %b", t2, a_load, exp_ld);
      else passed++;
      if (exp_ld) begin
        checks++;
        if (a_idx !== 4'd0 || a_pwr !== rep(32'd15000))
          $display("FAIL sopmid_pwr got idx=%0d pwr=%h required idx=0 pwr=all 15000", a_idx, a_pwr);
        else passed++;
      end
    end
  endtask

  task automatic test_single();
    logic exp_ld;
    for (int c = 0; c < 51; c++) begin
      if (c < 48) step(1, c == 0, 0, mk(c), c);
      else if (c == 48) step(1, 1, 1, mk(200), 200);
      else step(0, 0, 0, '0, -1);
      exp_ld = (t2 == 47) || (t2 == 200);
      checks++;
      if (a_load !== exp_ld) $display("FAIL single_load tag=%0d got %b required %b", t2, a_load, exp_ld);
      else passed++;
      if (exp_ld) begin
        checks++;
        if (a_idx !== 4'd0 || a_pwr !== rep((t2 == 200) ? 32'd312 : 32'd15000))
          $display("FAIL single_pwr tag=%0d got idx=%0d pwr=%h required idx=0 pwr=all %0d",
                   t2, a_idx, a_pwr, (t2 == 200) ? 312 : 15000);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_ld;
    for (int c = 0; c < 30; c++) step(1, c == 0, 0, big(), c);
    rst = 1'b1;
    step(1, 0, 0, big(), 30);
    checks++;
    if ({a_vld, a_sop, a_eop, a_load, a_idx} !== 8'h00 || a_data !== '0 || a_pwr !== '0)
      $display("FAIL midreset_outputs got vld=%b load=%b idx=%0d data=%h pwr=%h required all 0",
               a_vld, a_load, a_idx, a_data, a_pwr);
    else passed++;
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (c < 48) step(1, 0, 0, mk(c), 300 + c);
      else step(0, 0, 0, '0, -1);
      checks++;
      if ({a_vld, a_sop, a_eop} !== {v2, s2, e2} || a_data !== d2)
        $display("FAIL midreset_pass c=%0d got %b%b%b %h required %b%b%b %h", c, a_vld, a_sop, a_eop, a_data, v2, s2, e2, d2);
      else passed++;
      exp_ld = (t2 == 347);
      checks++;
      if (a_load !== exp_ld) $display("FAIL midreset_load tag=%0d got %b required %b", t2, a_load, exp_ld);
      else passed++;
      if (exp_ld) begin
        checks++;
        if (a_idx !== 4'd0 || a_pwr !== rep(32'd15000))
          $display("FAIL midreset_pwr got idx=%0d pwr=%h required idx=0 pwr=all 15000", a_idx, a_pwr);
        else passed++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; sop = 1'b0; eop = 1'b0; din = '0;
    d1 = '0; d2 = '0; v1 = 0; v2 = 0; s1 = 0; s2 = 0; e1 = 0; e2 = 0; t1 = -1; t2 = -1;
    test_reset();
    test_basic();
    test_gaps();
    test_partial();
    test_sat();
    test_wrap();
    test_sop_mid();
    test_single();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
